// File: rtl/noc_input_port_requester.sv
// noc_input_port_requester
// ------------------------
// Router input unit for one link direction. Incoming flits are buffered in a
// small credit-flow-controlled FIFO. The head flit of each packet is XY-routed
// (X first) and the resulting 3-bit next-hop code is requested from every output
// arbiter. The route is held from head to tail (wormhole). Each grant dequeues
// one flit, and each dequeue returns one credit upstream one cycle later.
//
// Optional feature macro: IPB_ERR_CHECK_EN
//   When defined, err_o is a sticky protocol-error flag. When undefined, err_o
//   is tied low.
//
// Ports:
//   clk             clock
//   reset           asynchronous, active-low reset
//   flit_valid_i    upstream flit present this cycle
//   flit_data_i     upstream flit; [FLIT_W-1:FLIT_W-2] holds the flit type
//   grant_i         OR of all output arbiter grants to this input
//   nexthop_addr_o  requested output: N=000 S=001 W=010 E=011 L=100 none=111
//   flit_o          current FIFO head flit (zero when the FIFO is empty)
//   credit_o        one-cycle credit pulse back to the upstream router
//   occupancy_o     registered FIFO fill level
//   err_o           sticky protocol error
module noc_input_port_requester #(
  parameter int FLIT_W   = 32,
  parameter int DEPTH    = 4,
  parameter int COORD_W  = 2,
  parameter int ROUTER_X = 0,
  parameter int ROUTER_Y = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flit_valid_i,
  input  logic [FLIT_W-1:0]            flit_data_i,
  input  logic                         grant_i,
  output logic [2:0]                   nexthop_addr_o,
  output logic [FLIT_W-1:0]            flit_o,
  output logic                         credit_o,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
  output logic                         err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  localparam logic [COORD_W-1:0] MY_X = COORD_W'(ROUTER_X);
  localparam logic [COORD_W-1:0] MY_Y = COORD_W'(ROUTER_Y);

  localparam logic [2:0] HOP_N    = 3'b000;
  localparam logic [2:0] HOP_S    = 3'b001;
  localparam logic [2:0] HOP_W    = 3'b010;
  localparam logic [2:0] HOP_E    = 3'b011;
  localparam logic [2:0] HOP_L    = 3'b100;
  localparam logic [2:0] HOP_NONE = 3'b111;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [FLIT_W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wrPtr;
  logic [PTR_W-1:0]      r_rdPtr;
  logic [CNT_W-1:0]      r_count;
  logic [2:0]            r_route;
  logic                  r_credit;

  logic                  w_empty;
  logic                  w_full;
  logic [FLIT_W-1:0]     w_head;
  logic [1:0]            w_headType;
  logic                  w_isHead;
  logic                  w_isTail;
  logic [COORD_W-1:0]    w_destX;
  logic [COORD_W-1:0]    w_destY;
  logic [2:0]            w_route;
  logic                  w_deq;
  logic                  w_enq;
  logic                  w_loadRoute;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_head     = r_mem[r_rdPtr];
  assign w_headType = w_head[FLIT_W-1:FLIT_W-2];
  // Type encoding: bit 0 marks a head (01/11), bit 1 marks a tail (10/11).
  assign w_isHead   = w_headType[0];
  assign w_isTail   = w_headType[1];
  assign w_destX    = w_head[2*COORD_W-1:COORD_W];
  assign w_destY    = w_head[COORD_W-1:0];

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_enq = flit_valid_i && (!w_full || w_deq);

  assign flit_o      = w_empty ? '0 : w_head;
  assign credit_o    = r_credit;
  assign occupancy_o = r_count;

  // XY routing on the head flit: resolve X first, then Y, else local.
  always_comb begin
    w_route = HOP_L;
    if (w_destX > MY_X)      w_route = HOP_E;
    else if (w_destX < MY_X) w_route = HOP_W;
    else if (w_destY > MY_Y) w_route = HOP_N;
    else if (w_destY < MY_Y) w_route = HOP_S;
  end

  // Next-state and request logic. A stray non-head flit in IDLE is dropped
  // (dequeued without a grant) so the port cannot lock up behind it.
  always_comb begin
    w_nextState    = r_state;
    w_deq          = 1'b0;
    w_loadRoute    = 1'b0;
    nexthop_addr_o = HOP_NONE;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          if (w_isHead) begin
            w_nextState = ACTIVE;
            w_loadRoute = 1'b1;
          end else begin
            w_deq = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (!w_empty) begin
          nexthop_addr_o = r_route;
          if (grant_i) begin
            w_deq = 1'b1;
            if (w_isTail) w_nextState = IDLE;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // State, pointers, fill level, held route and the registered credit pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_wrPtr  <= '0;
      r_rdPtr  <= '0;
      r_count  <= '0;
      r_route  <= HOP_NONE;
      r_credit <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_credit <= w_deq;
      if (w_enq) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_deq) r_rdPtr <= r_rdPtr + PTR_W'(1);
      r_count  <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
      if (w_loadRoute) r_route <= w_route;
    end
  end

  // Flit storage; contents need no reset because flit_o is gated by w_empty.
  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_wrPtr] <= flit_data_i;
  end

`ifdef IPB_ERR_CHECK_EN
  logic r_err;
  logic r_pastHead;
  logic w_errEvent;

  // Protocol violations: dropped write, orphan body/tail in IDLE, or a new
  // head reaching the FIFO head before the current packet's tail.
  always_comb begin
    w_errEvent = (flit_valid_i && w_full && !w_deq) ||
                 (r_state == IDLE && !w_empty && !w_isHead) ||
                 (r_state == ACTIVE && r_pastHead && !w_empty && w_isHead);
  end

  // r_pastHead marks that this packet's own head has already left the FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err      <= 1'b0;
      r_pastHead <= 1'b0;
    end else begin
      if (w_errEvent) r_err <= 1'b1;
      if (w_loadRoute) r_pastHead <= 1'b0;
      else if (r_state == ACTIVE && w_deq) r_pastHead <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: doc/noc_input_port_requester.md
Name: noc_input_port_requester

Overview:
- Per-direction router input unit; the requesting side of the per-output round-robin arbiters.
- Buffers incoming flits from the upstream link in a credit-flow-controlled FIFO.
- Computes the XY-routed next hop for each packet and drives the 3-bit nexthop code to all output arbiters.
- Dequeues one flit per grant and returns one credit upstream per dequeued flit. Wormhole: the route is held from head to tail.

Parameters:
- FLIT_W, 32, flit width in bits; bits [FLIT_W-1:FLIT_W-2] hold the flit type.
- DEPTH, 4, FIFO depth in flits (power of 2, ≥2); the upstream credit counter resets to this value.
- COORD_W, 2, width of each X/Y coordinate.
- ROUTER_X, 0, this router's X coordinate.
- ROUTER_Y, 0, this router's Y coordinate.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- flit_valid_i  input  1  upstream flit present this cycle
- flit_data_i  input  FLIT_W  upstream flit
- grant_i  input  1  OR of every output arbiter's grant to this input
- nexthop_addr_o  output  3  requested output: N=000, S=001, W=010, E=011, L=100, none=111
- flit_o  output  FLIT_W  FIFO head flit, to the crossbar
- credit_o  output  1  one-cycle pulse, one credit returned upstream
- occupancy_o  output  $clog2(DEPTH+1)  current FIFO fill level
- err_o  output  1  sticky protocol error (only with IPB_ERR_CHECK_EN)

Behaviour:
- Clocking and reset: one clock, clk. reset is asynchronous and active-low.
  - While reset=0: FIFO empty, occupancy_o=0, state=IDLE, nexthop_addr_o=111, credit_o=0, err_o=0, flit_o=0.
  - Reset mid-packet discards all buffered flits and emits no credits.
- Flit type field: 01=head, 00=body, 10=tail, 11=head+tail (single-flit packet).
- Head flit coordinates: dest_x=[2*COORD_W-1:COORD_W], dest_y=[COORD_W-1:0].
- Enqueue:
  - Occurs when flit_valid_i=1 and (occupancy<DEPTH or a dequeue happens in the same cycle).
  - A write when full with no dequeue is dropped.
  - Simultaneous enqueue and dequeue leaves occupancy unchanged.
- XY route, evaluated on the head flit, X first:
  - dest_x>ROUTER_X → E; dest_x<ROUTER_X → W.
  - Otherwise dest_y>ROUTER_Y → N; dest_y<ROUTER_Y → S.
  - Otherwise → L. Comparisons are unsigned.
- FSM states: IDLE, ACTIVE.
  - IDLE: nexthop_addr_o=111 and grant_i is ignored.
  - IDLE→ACTIVE: when the FIFO head is a head or head+tail flit. The computed route is registered on that edge.
  - A non-head flit at the FIFO head in IDLE is discarded (dequeued, credit returned) and flagged as an error if checking is enabled.
  - ACTIVE: nexthop_addr_o=route_q when the FIFO is non-empty, else 111 (the request drops while starved; route_q is held).
  - ACTIVE: grant_i=1 with a non-empty FIFO dequeues the head flit in that cycle. flit_o is combinationally the FIFO head.
  - ACTIVE→IDLE: on dequeue of a tail or head+tail flit. The next packet's route therefore costs one IDLE cycle, giving a minimum 1-cycle bubble between packets.
- Credits: credit_o pulses exactly one cycle after each dequeue, including discarded flits. The pulse is registered; there is exactly one pulse per dequeue.
- Pointers: read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. occupancy_o is registered.

Optional Feature:
- IPB_ERR_CHECK_EN defined — err_o is set, and stays set until reset, on any of:
  - a write while full without a dequeue;
  - a body/tail flit at the head in IDLE;
  - a head flit arriving at the FIFO head while ACTIVE, before the tail.
  The packet continues to be forwarded unchanged.
- IPB_ERR_CHECK_EN undefined — err_o is tied to 0; all other behaviour is identical.

Test Plan:
- Reset with ROUTER_X=1, ROUTER_Y=1; single head+tail flit dest (3,1):
  - nexthop_addr_o=011 one cycle after the flit reaches the FIFO head.
  - grant_i=1 → dequeue, credit_o=1 the next cycle, back to IDLE with nexthop_addr_o=111.
- Routing, same router: dest (1,3) → 000; dest (1,0) → 001; dest (0,2) → 010; dest (1,1) → 100.
- 4-flit packet (head, body, body, tail) with grant_i held at 1:
  - route stays constant for all flits;
  - 4 credit pulses on consecutive cycles;
  - the next packet's head sees one IDLE cycle.
- Fill DEPTH=4 with no grant → occupancy_o=4. A fifth write is dropped, occupancy stays 4, and err_o=1 with the macro (0 without).
- FIFO full plus a write and grant in the same cycle → the write is accepted and occupancy stays 4.
- reset asserted mid-packet (2 flits buffered) → immediately occupancy_o=0, nexthop_addr_o=111, and no credit pulse.
